// File: rtl/branch_predictor.sv
// Bimodal branch predictor: direct-mapped table of tag, target and 2-bit counter,
// combinational lookup at fetch and single-cycle update from the execute stage.
module branch_predictor #(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned MODE     = 1,
    parameter logic [1:0]  INIT_CNT = 2'b01
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_IF_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_pc,
    input  logic        i_upd_vld,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_pc,
    input  logic        i_clear,
    output logic        o_mispred,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [1:0]         cnt_mem    [ENTRIES];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [1:0]       up_cnt, cnt_inc, cnt_dec;
    logic             tbl_we;
    logic [31:0]      br_cnt_q, mispred_cnt_q;

    // The carried prediction bit is redundant with the carried next PC.
    logic unused_pred_taken;
    assign unused_pred_taken = i_upd_pred_taken;

    assign lk_idx = i_IF_pc[IDX+1:2];
    assign lk_tag = i_IF_pc[31:IDX+2];
    assign up_idx = i_upd_pc[IDX+1:2];
    assign up_tag = i_upd_pc[31:IDX+2];

    assign lk_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

    assign o_pred_taken  = (MODE == 1) && lk_hit && cnt_mem[lk_idx][1];
    assign o_pred_pc     = o_pred_taken ? target_mem[lk_idx] : i_IF_pc + 32'd4;
    assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;
    assign o_mispred     = i_upd_vld && (i_upd_pred_pc != o_redirect_pc);

    assign up_cnt  = cnt_mem[up_idx];
    assign cnt_inc = (up_cnt == 2'b11) ? up_cnt : up_cnt + 2'd1;
    assign cnt_dec = (up_cnt == 2'b00) ? up_cnt : up_cnt - 2'd1;
    assign tbl_we  = (MODE == 1) && i_upd_vld;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) cnt_mem[i] <= INIT_CNT;
        end else if (i_clear) begin
            valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) cnt_mem[i] <= INIT_CNT;
        end else if (tbl_we) begin
            if (i_upd_taken) begin
                valid[up_idx]   <= 1'b1;
                cnt_mem[up_idx] <= up_hit ? cnt_inc : 2'b10;
            end else if (up_hit) begin
                cnt_mem[up_idx] <= cnt_dec;
            end
        end
    end

    // Tag and target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge i_clk) begin
        if (tbl_we && i_upd_taken && !i_clear && i_reset) begin
            tag_mem[up_idx]    <= up_tag;
            target_mem[up_idx] <= i_upd_target;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (i_upd_vld && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 32'd1;
            if (o_mispred && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign o_br_cnt      = br_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic checked
// against a word-address table model; a MODE=0 instance runs alongside.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        upd_vld;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_pc;
    logic        clr;

    logic        pred_taken, mispred, pred_taken0, mispred0;
    logic [31:0] pred_pc, redirect_pc, br_cnt, mispred_cnt;
    logic [31:0] pred_pc0, redirect_pc0, br_cnt0, mispred_cnt0;

    int errors = 0;
    int checks = 0;

    // Model: each slot remembers the full word address that allocated it.
    bit          m_valid [64];
    logic [29:0] m_word  [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [64];
    logic [31:0] m_br, m_br0, m_mp;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64), .MODE(1), .INIT_CNT(2'b01)) dut (
        .i_clk(clk), .i_reset(rst), .i_IF_pc(if_pc),
        .o_pred_taken(pred_taken), .o_pred_pc(pred_pc),
        .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
        .i_upd_target(upd_target), .i_upd_pred_taken(upd_pred_taken),
        .i_upd_pred_pc(upd_pred_pc), .i_clear(clr),
        .o_mispred(mispred), .o_redirect_pc(redirect_pc),
        .o_br_cnt(br_cnt), .o_mispred_cnt(mispred_cnt)
    );

    branch_predictor #(.ENTRIES(64), .MODE(0), .INIT_CNT(2'b01)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_IF_pc(if_pc),
        .o_pred_taken(pred_taken0), .o_pred_pc(pred_pc0),
        .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
        .i_upd_target(upd_target), .i_upd_pred_taken(upd_pred_taken),
        .i_upd_pred_pc(upd_pred_pc), .i_clear(clr),
        .o_mispred(mispred0), .o_redirect_pc(redirect_pc0),
        .o_br_cnt(br_cnt0), .o_mispred_cnt(mispred_cnt0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'(pc[31:2] % 30'd64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_word[slot(pc)] == pc[31:2]);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        if (m_hit(pc) && m_cnt[slot(pc)] >= 2) return m_tgt[slot(pc)];
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] m_redirect();
        return upd_taken ? upd_target : upd_pc + 32'd4;
    endfunction

    function automatic bit m_mispred();
        return upd_vld && (upd_pred_pc != m_redirect());
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_br = '0; m_br0 = '0; m_mp = '0;
    endtask

    task automatic check_all();
        logic [31:0] exp_next;
        exp_next = m_next(if_pc);
        check("pred_taken", pred_taken, 32'(exp_next != if_pc + 32'd4 || (m_hit(if_pc) && m_cnt[slot(if_pc)] >= 2)));
        check("pred_pc", pred_pc, exp_next);
        check("mispred", mispred, 32'(m_mispred()));
        check("redirect_pc", redirect_pc, m_redirect());
        check("br_cnt", br_cnt, m_br);
        check("mispred_cnt", mispred_cnt, m_mp);
        check("m0_pred_taken", pred_taken0, 32'd0);
        check("m0_pred_pc", pred_pc0, if_pc + 32'd4);
        check("m0_mispred", mispred0, 32'(m_mispred()));
        check("m0_br_cnt", br_cnt0, m_br0);
        check("m0_mispred_cnt", mispred_cnt0, m_mp);
    endtask

    task automatic apply(input logic [31:0] pc, input logic vld, input logic [31:0] upc,
                         input logic tk, input logic [31:0] tgt, input logic [31:0] ppc,
                         input logic c);
        if_pc = pc; upd_vld = vld; upd_pc = upc; upd_taken = tk;
        upd_target = tgt; upd_pred_pc = ppc; clr = c;
        upd_pred_taken = (ppc != upc + 32'd4);
        #1;
        check_all();
    endtask

    // Advance one clock and apply the same edge to the model, then park at the falling edge.
    task automatic tick();
        bit mp;
        int j;
        mp = m_mispred();
        @(posedge clk);
        if (rst) begin
            if (upd_vld && m_br != '1) m_br = m_br + 1;
            if (upd_vld && m_br0 != '1) m_br0 = m_br0 + 1;
            if (mp && m_mp != '1) m_mp = m_mp + 1;
            if (clr) begin
                for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            end else if (upd_vld) begin
                j = slot(upd_pc);
                if (upd_taken) begin
                    if (m_hit(upd_pc)) m_cnt[j] = (m_cnt[j] < 3) ? m_cnt[j] + 1 : 3;
                    else begin
                        m_valid[j] = 1'b1; m_word[j] = upd_pc[31:2]; m_cnt[j] = 2;
                    end
                    m_tgt[j] = upd_target;
                end else if (m_hit(upd_pc)) begin
                    m_cnt[j] = (m_cnt[j] > 0) ? m_cnt[j] - 1 : 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] pc);
        apply(pc, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0);
    endtask

    task automatic random_steps(input int n);
        logic [31:0] upc, ipc, tgt, ppc;
        int sel;
        for (int k = 0; k < n; k++) begin
            upc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 15) == 0) upc = upc | 32'hFFFF_F000;
            ipc = ($urandom_range(0, 3) == 0) ? upc
                  : (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            tgt = $urandom & 32'hFFFF_FFFC;
            sel = $urandom_range(0, 2);
            ppc = (sel == 0) ? upc + 32'd4 : (sel == 1) ? m_next(upc) : tgt;
            apply(ipc, 1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 1)), tgt, ppc,
                  1'($urandom_range(0, 49) == 0));
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            m_word[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
        end
        idle(32'h100);
        @(negedge clk);
        idle(32'h100);
        check("cold_taken", pred_taken, 32'd0);
        check("cold_pc", pred_pc, 32'h104);
        check("reset_br", br_cnt, 32'd0);
        rst = 1'b1;

        // Allocate then hit
        apply(32'h100, 1, 32'h100, 1, 32'h40, 32'h104, 0);
        check("alloc_mispred", mispred, 32'd1);
        check("alloc_redirect", redirect_pc, 32'h40);
        check("alloc_m0_mispred", mispred0, 32'd1);
        tick();
        idle(32'h100);
        check("hit_taken", pred_taken, 32'd1);
        check("hit_pc", pred_pc, 32'h40);
        check("hit_m0_taken", pred_taken0, 32'd0);
        tick();

        // Hysteresis: 10 -> 01 -> 00 -> 01
        apply(32'h100, 1, 32'h100, 0, 32'h0, 32'h40, 0); tick();
        apply(32'h100, 1, 32'h100, 0, 32'h0, 32'h104, 0); tick();
        idle(32'h100);
        check("hyst_00_pc", pred_pc, 32'h104);
        tick();
        apply(32'h100, 1, 32'h100, 1, 32'h40, 32'h104, 0); tick();
        idle(32'h100);
        check("hyst_01_taken", pred_taken, 32'd0);
        tick();

        // Aliasing on slot 0
        apply(32'h100, 1, 32'h100, 1, 32'h40, 32'h104, 0); tick();
        idle(32'h100);
        check("alias_pre", pred_pc, 32'h40);
        apply(32'h100, 1, 32'h200, 1, 32'h80, 32'h204, 0); tick();
        idle(32'h100);
        check("alias_evict", pred_taken, 32'd0);
        tick();
        idle(32'h200);
        check("alias_new", pred_pc, 32'h80);
        tick();

        // PC wrap and no-bypass
        apply(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
        check("wrap_pred", pred_pc, 32'h0);
        check("wrap_redirect", redirect_pc, 32'h0);
        check("wrap_mispred", mispred, 32'd0);
        tick();
        apply(32'h300, 1, 32'h300, 1, 32'h500, 32'h304, 0);
        check("bypass_old", pred_taken, 32'd0);
        tick();
        idle(32'h300);
        check("bypass_new", pred_pc, 32'h500);
        tick();

        // Clear beats a simultaneous update, which still counts
        apply(32'h200, 1, 32'h400, 1, 32'h600, 32'h404, 1); tick();
        idle(32'h200);
        check("clear_200", pred_taken, 32'd0);
        idle(32'h400);
        check("clear_400", pred_taken, 32'd0);
        idle(32'h300);
        check("clear_300", pred_taken, 32'd0);
        tick();

        random_steps(400);

        // Saturation of the branch counter
        force dut.br_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_cnt_q;
        m_br = 32'hFFFF_FFFF;
        apply(32'h100, 1, 32'h100, 1, 32'h40, 32'h40, 0);
        tick();
        idle(32'h100);
        check("br_saturate", br_cnt, 32'hFFFF_FFFF);
        tick();

        // Reset in the middle of an update
        apply(32'h700, 1, 32'h700, 1, 32'h900, 32'h704, 0);
        rst = 1'b0;
        model_reset();
        #1;
        check("midrst_br", br_cnt, 32'd0);
        check("midrst_mp", mispred_cnt, 32'd0);
        tick();
        idle(32'h700);
        check("midrst_drop", pred_taken, 32'd0);
        rst = 1'b1;
        tick();
        random_steps(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
